// File: rtl/float16_pkg.sv
// rtl/float16_pkg.sv - shared float16 format constants and types
package float16_pkg;

  localparam int FP16_W     = 16;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_SIG_W = 10;
  localparam int FP16_BIAS  = 15;

  typedef logic [FP16_W-1:0] fp16_t;

  typedef struct packed {
    logic                  sign;
    logic [FP16_EXP_W-1:0] exp;
    logic [FP16_SIG_W-1:0] frac;
  } fp16_fields_t;

  localparam fp16_t FP16_ONE  = 16'h3C00;
  localparam fp16_t FP16_INF  = 16'h7C00;
  localparam fp16_t FP16_QNAN = 16'h7E00;

endpackage

// File: rtl/float16_multiplier.sv
// rtl/float16_multiplier.sv - combinational float16 multiply, round-to-nearest-even
// Subnormal inputs and results flush to signed zero; of_o flags finite overflow to inf.
module float16_multiplier
  import float16_pkg::*;
(
  input  fp16_t a_i,
  input  fp16_t b_i,
  output fp16_t c_o,
  output logic  of_o
);

  fp16_fields_t      fa, fb;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign;
  logic [10:0]       ma, mb, mant;
  logic [21:0]       prod;
  logic              guard, sticky, round_up;
  logic [11:0]       mant_rnd;
  logic [9:0]        frac;
  logic signed [7:0] exp_r;

  assign fa     = a_i;
  assign fb     = b_i;
  assign a_zero = (fa.exp == '0);
  assign b_zero = (fb.exp == '0);
  assign a_inf  = (&fa.exp) && (fa.frac == '0);
  assign b_inf  = (&fb.exp) && (fb.frac == '0);
  assign a_nan  = (&fa.exp) && (fa.frac != '0);
  assign b_nan  = (&fb.exp) && (fb.frac != '0);
  assign sign   = fa.sign ^ fb.sign;
  assign ma     = {1'b1, fa.frac};
  assign mb     = {1'b1, fb.frac};
  assign prod   = {11'b0, ma} * {11'b0, mb};

  // Product of two [1,2) significands lies in [1,4); bit 21 selects the extra shift.
  always_comb begin
    if (prod[21]) begin
      mant   = prod[21:11];
      guard  = prod[10];
      sticky = |prod[9:0];
    end else begin
      mant   = prod[20:10];
      guard  = prod[9];
      sticky = |prod[8:0];
    end
  end

  assign round_up = guard & (sticky | mant[0]);
  assign mant_rnd = {1'b0, mant} + {11'b0, round_up};
  assign frac     = mant_rnd[11] ? mant_rnd[10:1] : mant_rnd[9:0];
  assign exp_r    = $signed({3'b000, fa.exp}) + $signed({3'b000, fb.exp})
                  - $signed(8'(FP16_BIAS))
                  + $signed({7'b0, prod[21]}) + $signed({7'b0, mant_rnd[11]});

  always_comb begin
    c_o  = '0;
    of_o = 1'b0;
    if (a_nan || b_nan) begin
      c_o = FP16_QNAN;
    end else if (a_inf || b_inf) begin
      c_o = (a_zero || b_zero) ? FP16_QNAN : {sign, FP16_INF[14:0]};
    end else if (a_zero || b_zero) begin
      c_o = {sign, 15'b0};
    end else if (exp_r >= 8'sd31) begin
      c_o  = {sign, FP16_INF[14:0]};
      of_o = 1'b1;
    end else if (exp_r <= 8'sd0) begin
      c_o = {sign, 15'b0};
    end else begin
      c_o = {sign, exp_r[4:0], frac};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
// Searches req_i starting at ptr_i, wrapping, and grants the first set bit.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_vld_o
);

  logic [IDX_W:0] cand;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    cand        = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N)) begin
        cand = cand - (IDX_W+1)'(N);
      end
      if (!grant_vld_o && req_i[cand[IDX_W-1:0]]) begin
        grant_vld_o                 = 1'b1;
        grant_o[cand[IDX_W-1:0]]    = 1'b1;
        grant_idx_o                 = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/float16_mul_arbiter.sv
// rtl/float16_mul_arbiter.sv - round-robin shared float16 multiplier, 2-stage pipeline
// S1 holds operands feeding the combinational multiplier; S2 holds the result and drives rsp_*.
module float16_mul_arbiter
  import float16_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int OFCNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_c,
  output logic                  rsp_of,
  output logic                  busy,
  output logic [OFCNT_W-1:0]    of_count,
  input  logic                  of_clear
);

  logic               s1_vld_q, s1_vld_d;
  fp16_t              s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [ID_W-1:0]    s1_id_q, s1_id_d;
  logic               s2_vld_q, s2_vld_d;
  fp16_t              s2_c_q, s2_c_d;
  logic               s2_of_q, s2_of_d;
  logic [ID_W-1:0]    s2_id_q, s2_id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [OFCNT_W-1:0] of_count_q, of_count_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_vld;
  logic               s1_adv, s2_adv, accept, rsp_hs;
  fp16_t              sel_a, sel_b, mul_c;
  logic               mul_of;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(ID_W)) u_arb (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (gnt),
    .grant_idx_o (gnt_idx),
    .grant_vld_o (gnt_vld)
  );

  float16_multiplier u_mul (
    .a_i  (s1_a_q),
    .b_i  (s1_b_q),
    .c_o  (mul_c),
    .of_o (mul_of)
  );

  assign s2_adv    = !s2_vld_q || rsp_ready;
  assign s1_adv    = !s1_vld_q || s2_adv;
  assign accept    = gnt_vld && s1_adv;
  assign rsp_hs    = s2_vld_q && rsp_ready;
  assign req_ready = s1_adv ? gnt : '0;
  assign sel_a     = req_a[16*gnt_idx +: 16];
  assign sel_b     = req_b[16*gnt_idx +: 16];

  always_comb begin
    s1_vld_d   = s1_vld_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    s2_vld_d   = s2_vld_q;
    s2_c_d     = s2_c_q;
    s2_of_d    = s2_of_q;
    s2_id_d    = s2_id_q;
    rr_ptr_d   = rr_ptr_q;
    of_count_d = of_count_q;

    if (s1_adv) begin
      s1_vld_d = accept;
      if (accept) begin
        s1_a_d  = sel_a;
        s1_b_d  = sel_b;
        s1_id_d = gnt_idx;
      end
    end

    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_c_d  = mul_c;
        s2_of_d = mul_of;
        s2_id_d = s1_id_q;
      end
    end

    if (accept) begin
      rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
    end

    // Clear takes priority over a same-cycle overflow delivery.
    if (of_clear) begin
      of_count_d = '0;
    end else if (rsp_hs && s2_of_q && !(&of_count_q)) begin
      of_count_d = of_count_q + OFCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_vld_q   <= 1'b0;
      s2_c_q     <= '0;
      s2_of_q    <= 1'b0;
      s2_id_q    <= '0;
      rr_ptr_q   <= '0;
      of_count_q <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_vld_q   <= s2_vld_d;
      s2_c_q     <= s2_c_d;
      s2_of_q    <= s2_of_d;
      s2_id_q    <= s2_id_d;
      rr_ptr_q   <= rr_ptr_d;
      of_count_q <= of_count_d;
    end
  end

  assign rsp_valid = s2_vld_q;
  assign rsp_c     = s2_c_q;
  assign rsp_of    = s2_of_q;
  assign rsp_id    = s2_id_q;
  assign busy      = s1_vld_q || s2_vld_q;
  assign of_count  = of_count_q;

endmodule

// File: tb/tb_float16_mul_arbiter.sv
// tb/tb_float16_mul_arbiter.sv - directed self-checking bench for float16_mul_arbiter
module tb_float16_mul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int OFCNT_W = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_a = '0;
  logic [16*NUM_REQ-1:0] req_b = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [ID_W-1:0]       rsp_id;
  logic [15:0]           rsp_c;
  logic                  rsp_of;
  logic                  busy;
  logic [OFCNT_W-1:0]    of_count;
  logic                  of_clear = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] ta [4] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
  logic [15:0] tc [4] = '{16'h4000, 16'h4400, 16'h4600, 16'h4800};

  always #5 clk = ~clk;

  float16_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .OFCNT_W(OFCNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_c     (rsp_c),
    .rsp_of    (rsp_of),
    .busy      (busy),
    .of_count  (of_count),
    .of_clear  (of_clear)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    of_clear  = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run_op(input int lane, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_c, input logic exp_of);
    req_a[16*lane +: 16] = a;
    req_b[16*lane +: 16] = b;
    req_valid = 4'(1 << lane);
    rsp_ready = 1'b1;
    #1;
    check("op_ready", 32'(req_ready), 32'(1) << lane);
    tick();
    req_valid = '0;
    #1;
    check("op_lat1_valid", 32'(rsp_valid), 0);
    tick();
    check("op_valid", 32'(rsp_valid), 1);
    check("op_c", 32'(rsp_c), 32'(exp_c));
    check("op_of", 32'(rsp_of), 32'(exp_of));
    check("op_id", 32'(rsp_id), 32'(lane));
    tick();
    check("op_drained", 32'(rsp_valid), 0);
  endtask

  // Protocol monitors sampled on the falling edge.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_rsp   = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      check("ready_onehot0", 32'($onehot0(req_ready)), 1);
      if (prev_stall) begin
        check("stall_valid", 32'(rsp_valid), 1);
        check("stall_stable", 32'({rsp_id, rsp_c, rsp_of}), prev_rsp);
      end
      prev_stall <= rsp_valid & ~rsp_ready;
      prev_rsp   <= 32'({rsp_id, rsp_c, rsp_of});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit exceeded, got running expected finished");
    $fatal(1, "watchdog");
  end

  logic [NUM_REQ-1:0] pend, hs;
  int                 nres;
  logic [ID_W-1:0]    got_id  [8];
  logic [15:0]        got_c   [8];
  int                 got_cyc [8];

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ofcnt", 32'(of_count), 0);
    check("rst_c", 32'(rsp_c), 0);
    rst_n = 1'b1;
    tick();

    // 1: single op
    run_op(0, 16'h3C00, 16'h4000, 16'h4000, 1'b0);

    // 2: all requesters valid every cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[16*i +: 16] = ta[i];
      req_b[16*i +: 16] = 16'h4000;
    end
    for (int k = 0; k < 9; k++) begin
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      if (k < 8) check("rr_grant", 32'(req_ready), 32'(1) << (k % 4));
      tick();
      if (k >= 1) begin
        check("rr_valid", 32'(rsp_valid), 1);
        check("rr_id", 32'(rsp_id), 32'((k - 1) % 4));
        check("rr_c", 32'(rsp_c), 32'(tc[(k - 1) % 4]));
      end
    end
    tick();
    check("rr_drain", 32'(rsp_valid), 0);

    // 3: backpressure with three queued ops
    do_reset();
    rsp_ready = 1'b0;
    pend = 4'b0111;
    for (int k = 0; k < 5; k++) begin
      req_valid = pend;
      #1;
      hs = req_ready & pend;
      if (k >= 2) check("bp_ready_zero", 32'(req_ready), 0);
      tick();
      pend = pend & ~hs;
    end
    check("bp_pending", 32'(pend), 32'h4);
    check("bp_busy", 32'(busy), 1);
    check("bp_head_id", 32'(rsp_id), 0);
    rsp_ready = 1'b1;
    nres = 0;
    for (int k = 0; k < 8; k++) begin
      req_valid = pend;
      #1;
      hs = req_ready & pend;
      if (rsp_valid) begin
        got_id[nres]  = rsp_id;
        got_c[nres]   = rsp_c;
        got_cyc[nres] = k;
        nres++;
      end
      tick();
      pend = pend & ~hs;
    end
    req_valid = '0;
    check("bp_count", 32'(nres), 3);
    for (int i = 0; i < 3 && i < nres; i++) begin
      check("bp_id", 32'(got_id[i]), 32'(i));
      check("bp_c", 32'(got_c[i]), 32'(tc[i]));
      check("bp_no_bubble", 32'(got_cyc[i]), 32'(i));
    end

    // 4: arithmetic through requester 2
    do_reset();
    run_op(2, 16'hBE00, 16'h4000, 16'hC200, 1'b0);
    check("ar_ofcnt0", 32'(of_count), 0);
    run_op(2, 16'h7BFF, 16'h7BFF, 16'h7C00, 1'b1);
    check("ar_ofcnt1", 32'(of_count), 1);

    // 5: of_count saturation and clear priority
    do_reset();
    req_a[15:0] = 16'h7BFF;
    req_b[15:0] = 16'h7BFF;
    req_valid = 4'b0001;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (k == 101) check("ofc_mid", 32'(of_count), 100);
      if (k == 256) check("ofc_sat", 32'(of_count), 255);
    end
    req_valid = '0;
    repeat (3) tick();
    check("ofc_sat_final", 32'(of_count), 255);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    check("ofc_clr_pre_of", 32'(rsp_of), 1);
    of_clear = 1'b1;
    tick();
    of_clear = 1'b0;
    check("ofc_clear_wins", 32'(of_count), 0);
    run_op(0, 16'h7BFF, 16'h7BFF, 16'h7C00, 1'b1);
    check("ofc_after_clear", 32'(of_count), 1);

    // 6: async reset with both stages full
    do_reset();
    rsp_ready = 1'b0;
    req_a[31:16] = 16'h4000;
    req_b[31:16] = 16'h4000;
    pend = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      req_valid = pend;
      #1;
      hs = req_ready & pend;
      tick();
      pend = pend & ~hs;
    end
    req_valid = '0;
    #1;
    check("ar_pre_valid", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    #1;
    check("ar_async_valid", 32'(rsp_valid), 0);
    check("ar_async_busy", 32'(busy), 0);
    check("ar_async_c", 32'(rsp_c), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ar_no_ghost", 32'(rsp_valid), 0);
    end
    run_op(3, 16'h4400, 16'h4400, 16'h4C00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
